// File: rtl/lc3_decode_pkg.sv
// rtl/lc3_decode_pkg.sv - shared opcode, control-field types and constants for the LC3 decode stage
//
// Contents: opcode_t enum, e_control_t packed struct, ALU/PC-select/operand-select
// field constants, w_control constants, and is_illegal() helper used by the
// optional illegal-opcode logic (macro LC3_DECODE_ILLEGAL_EN).

package lc3_decode_pkg;

  localparam int INSN_W_DEF   = 16;
  localparam int E_CTRL_W_DEF = 6;
  localparam int W_CTRL_W_DEF = 2;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  // Field order matches the bus: {alu_control, pcselect1, pcselect2, op2select}
  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_control_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
  localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
  localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
  localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

  // pcselect2: 1 adds the offset to NPC, 0 adds it to a base register
  localparam logic PCSEL2_NPC  = 1'b1;
  localparam logic PCSEL2_BASE = 1'b0;

  localparam logic OP2_IMM = 1'b0;
  localparam logic OP2_REG = 1'b1;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  function automatic logic is_illegal(input logic [3:0] opcode);
    return (opcode == OP_RTI) || (opcode == OP_RES) ||
           (opcode == OP_JSR) || (opcode == OP_TRAP);
  endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// rtl/lc3_decode_ctrl.sv - combinational opcode to control-field table
//
// Ports:
//   insn      in  16  instruction word (opcode in [15:12], imm flag in [5])
//   e_ctrl    out  6  execute control {alu_control, pcselect1, pcselect2, op2select}
//   w_ctrl    out  2  writeback select
//   mem_ind   out  1  indirect memory access (LDI/STI)

module lc3_decode_ctrl
  import lc3_decode_pkg::*;
(
  input  logic [15:0] insn,
  output e_control_t  e_ctrl,
  output logic [1:0]  w_ctrl,
  output logic        mem_ind
);

  opcode_t opcode;
  logic    imm_sel;

  assign opcode  = opcode_t'(insn[15:12]);
  assign imm_sel = insn[5];

  always_comb begin
    e_ctrl  = '{alu_control: ALU_ADD, pcselect1: PCSEL1_OFF11,
                pcselect2: PCSEL2_BASE, op2select: OP2_IMM};
    w_ctrl  = WB_ALU;
    mem_ind = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        e_ctrl.alu_control = ALU_ADD;
        e_ctrl.op2select   = imm_sel ? OP2_IMM : OP2_REG;
      end
      OP_AND: begin
        e_ctrl.alu_control = ALU_AND;
        e_ctrl.op2select   = imm_sel ? OP2_IMM : OP2_REG;
      end
      OP_NOT: begin
        e_ctrl.alu_control = ALU_NOT;
      end
      OP_BR, OP_ST: begin
        e_ctrl.pcselect1 = PCSEL1_OFF9;
        e_ctrl.pcselect2 = PCSEL2_NPC;
      end
      OP_LD: begin
        e_ctrl.pcselect1 = PCSEL1_OFF9;
        e_ctrl.pcselect2 = PCSEL2_NPC;
        w_ctrl           = WB_MEM;
      end
      OP_LDI: begin
        e_ctrl.pcselect1 = PCSEL1_OFF9;
        e_ctrl.pcselect2 = PCSEL2_NPC;
        w_ctrl           = WB_MEM;
        mem_ind          = 1'b1;
      end
      OP_STI: begin
        e_ctrl.pcselect1 = PCSEL1_OFF9;
        e_ctrl.pcselect2 = PCSEL2_NPC;
        mem_ind          = 1'b1;
      end
      OP_LEA: begin
        e_ctrl.pcselect1 = PCSEL1_OFF9;
        e_ctrl.pcselect2 = PCSEL2_NPC;
        w_ctrl           = WB_PC;
      end
      OP_LDR: begin
        e_ctrl.pcselect1 = PCSEL1_OFF6;
        w_ctrl           = WB_MEM;
      end
      OP_STR: begin
        e_ctrl.pcselect1 = PCSEL1_OFF6;
      end
      OP_JMP: begin
        e_ctrl.pcselect1 = PCSEL1_ZERO;
      end
      // RTI, JSR, reserved and TRAP keep the all-zero defaults
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_decode_stage.sv
// rtl/lc3_decode_stage.sv - LC3 decode pipeline stage with registered control outputs
//
// Ports:
//   clock          in   1  rising-edge clock
//   reset          in   1  asynchronous active-low reset
//   enable_decode  in   1  stage advance; all outputs load only when high
//   dout           in  16  instruction from fetch
//   npc_in         in  16  PC+1 from fetch
//   ir             out 16  registered instruction
//   npc_out        out 16  registered npc_in
//   e_control      out  6  {alu_control, pcselect1, pcselect2, op2select}
//   mem_control    out  1  indirect access (LDI/STI)
//   w_control      out  2  00 ALU, 01 memory, 10 PC/address
// Optional (macro LC3_DECODE_ILLEGAL_EN):
//   illegal_op     out  1  registered flag for RTI/JSR/reserved/TRAP
//   illegal_cnt    out 16  saturating count of illegal instructions decoded

module lc3_decode_stage
  import lc3_decode_pkg::*;
#(
  parameter int INSN_W   = INSN_W_DEF,
  parameter int E_CTRL_W = E_CTRL_W_DEF,
  parameter int W_CTRL_W = W_CTRL_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_decode,
  input  logic [INSN_W-1:0]   dout,
  input  logic [INSN_W-1:0]   npc_in,
  output logic [INSN_W-1:0]   ir,
  output logic [INSN_W-1:0]   npc_out,
  output logic [E_CTRL_W-1:0] e_control,
  output logic                mem_control,
  output logic [W_CTRL_W-1:0] w_control
`ifdef LC3_DECODE_ILLEGAL_EN
  ,
  output logic                illegal_op,
  output logic [15:0]         illegal_cnt
`endif
);

  e_control_t  e_next;
  logic [1:0]  w_next;
  logic        m_next;

  lc3_decode_ctrl u_ctrl (
    .insn    (dout),
    .e_ctrl  (e_next),
    .w_ctrl  (w_next),
    .mem_ind (m_next)
  );

  // ir, npc and all control fields load in the same edge so they always
  // describe one instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir          <= '0;
      npc_out     <= '0;
      e_control   <= '0;
      w_control   <= '0;
      mem_control <= 1'b0;
    end else if (enable_decode) begin
      ir          <= dout;
      npc_out     <= npc_in;
      e_control   <= e_next;
      w_control   <= w_next;
      mem_control <= m_next;
    end
  end

`ifdef LC3_DECODE_ILLEGAL_EN
  logic ill_next;
  assign ill_next = is_illegal(dout[15:12]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_op  <= 1'b0;
      illegal_cnt <= '0;
    end else if (enable_decode) begin
      illegal_op <= ill_next;
      if (ill_next && (illegal_cnt != 16'hFFFF))
        illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule
